// File: rtl/sr04_pkg.sv
// Shared definitions for the HC-SR04 measurement path: FSM encoding and default timing.
package sr04_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    localparam int unsigned TRIG_US      = 10;
    localparam int unsigned ECHO_WAIT_US = 30000;
    localparam int unsigned ECHO_MAX_US  = 36200;
    localparam int unsigned HOLDOFF_US   = 60000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input plus one-clock rise/fall pulses.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rise_c = sync_q & ~dly_q;
    assign fall_c = ~sync_q & dly_q;

endmodule

// File: rtl/sr04_ctrl.sv
// HC-SR04 measurement sequencer: trigger pulse, echo wait, echo-window gating of the
// pulse counter, timeouts and inter-measurement holdoff.
module sr04_ctrl #(
    parameter int unsigned TRIG_US      = sr04_pkg::TRIG_US,
    parameter int unsigned ECHO_WAIT_US = sr04_pkg::ECHO_WAIT_US,
    parameter int unsigned ECHO_MAX_US  = sr04_pkg::ECHO_MAX_US,
    parameter int unsigned HOLDOFF_US   = sr04_pkg::HOLDOFF_US
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1us,
    input  logic start,
    input  logic stop,
    input  logic echo,
    output logic trigger,
    output logic echo_cnt_en,
    output logic echo_cnt_reset,
    output logic busy,
    output logic done,
    output logic err
);

    import sr04_pkg::*;

    localparam int unsigned MAX_US = max_u(max_u(TRIG_US, ECHO_WAIT_US),
                                           max_u(ECHO_MAX_US, HOLDOFF_US));
    localparam int unsigned CNT_W  = $clog2(MAX_US) + 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   us_cnt, us_cnt_nxt;
    logic               trig_nxt, en_nxt, cnt_rst_nxt, busy_nxt, done_nxt, err_nxt;
    logic               echo_rise_c, echo_fall_c;

    sync_edge_det u_echo_sync (
        .clk    (clk),
        .rst_n  (reset),
        .din    (echo),
        .rise_c (echo_rise_c),
        .fall_c (echo_fall_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            us_cnt         <= '0;
            trigger        <= 1'b0;
            echo_cnt_en    <= 1'b0;
            echo_cnt_reset <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_nxt;
            us_cnt         <= us_cnt_nxt;
            trigger        <= trig_nxt;
            echo_cnt_en    <= en_nxt;
            echo_cnt_reset <= cnt_rst_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            err            <= err_nxt;
        end
    end

    // Edge events are checked before timeouts so a coincident valid edge wins.
    always_comb begin
        state_nxt   = state;
        cnt_rst_nxt = 1'b0;
        done_nxt    = 1'b0;
        err_nxt     = err;

        if (stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt   = S_TRIG;
                        cnt_rst_nxt = 1'b1;
                        err_nxt     = 1'b0;
                    end
                end
                S_TRIG: begin
                    if (tick_1us && us_cnt == CNT_W'(TRIG_US - 1))
                        state_nxt = S_WAIT_ECHO;
                end
                S_WAIT_ECHO: begin
                    if (echo_rise_c) begin
                        state_nxt = S_MEASURE;
                    end else if (tick_1us && us_cnt == CNT_W'(ECHO_WAIT_US - 1)) begin
                        state_nxt = S_HOLDOFF;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (echo_fall_c) begin
                        state_nxt = S_HOLDOFF;
                        done_nxt  = 1'b1;
                    end else if (tick_1us && us_cnt == CNT_W'(ECHO_MAX_US - 1)) begin
                        state_nxt = S_HOLDOFF;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (tick_1us && us_cnt == CNT_W'(HOLDOFF_US - 1))
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        if (state_nxt != state || state == S_IDLE)
            us_cnt_nxt = '0;
        else if (tick_1us)
            us_cnt_nxt = us_cnt + CNT_W'(1);
        else
            us_cnt_nxt = us_cnt;

        trig_nxt = (state_nxt == S_TRIG);
        en_nxt   = (state_nxt == S_MEASURE);
        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule
